trap_sequencer: RTL and testbench

Multi-cycle controller that sequences the machine-mode context switch on an exception, interrupt or MRET. Sits between the pipeline's trap-cause flags and the CSR file's single write port. Prioritises pending events, latches the cause, and stalls and flushes the pipeline. It then issues ordered CSR writes (mepc, mcause, mtval, mstatus) and finally redirects the PC. It also owns the current privilege register.

---
 rtl/trap_sequencer.sv | 173 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET context-switch sequencer: prioritises events, issues ordered CSR writes, redirects the PC.
// Optional macro VECTORED_MTVEC_EN: interrupts with MTVEC[1:0]=01 redirect to base + 4*cause.
module trap_sequencer #(
    parameter int XLEN        = 64,
    parameter int MTVEC_ALIGN = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            F_IAM,
    input  logic            F_IAF,
    input  logic            F_II,
    input  logic            MEM_LAM,
    input  logic            MEM_LAF,
    input  logic            MEM_SAM,
    input  logic            MEM_SAF,
    input  logic            ECALL,
    input  logic            MRET,
    input  logic            TIMER,
    input  logic            EXTERNAL,
    input  logic [XLEN-1:0] F_PC,
    input  logic [XLEN-1:0] MEM_PC,
    input  logic [XLEN-1:0] MEM_ADDR,
    input  logic [31:0]     F_INSTR,
    input  logic [XLEN-1:0] MSTATUS,
    input  logic [XLEN-1:0] MIE_REG,
    input  logic [XLEN-1:0] MTVEC,
    input  logic [XLEN-1:0] MEPC,
    output logic            CSR_WE,
    output logic [11:0]     CSR_WADDR,
    output logic [XLEN-1:0] CSR_WDATA,
    output logic            STALL,
    output logic            FLUSH,
    output logic            REDIRECT,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic [1:0]      PRIVILEGE,
    output logic            BUSY
);

    typedef enum logic [2:0] {
        IDLE, S_EPC, S_CAUSE, S_TVAL, S_STATUS, S_REDIR, R_STATUS, R_REDIR
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(MTVEC_ALIGN - 1));

    state_t            r_state, w_next;
    logic [XLEN-1:0]   r_cause, r_epc, r_tval;
    logic [1:0]        r_mpp;
    logic              w_trap, w_mem, w_int_ext, w_int_tmr;
    logic [XLEN-1:0]   w_cause, w_tval, w_epc, w_base;
    logic [XLEN-1:0]   w_mst_trap, w_mst_mret;
    logic              w_unused;

    assign w_int_ext = EXTERNAL & MSTATUS[3] & MIE_REG[11];
    assign w_int_tmr = TIMER    & MSTATUS[3] & MIE_REG[7];
    assign w_unused  = &{1'b0, MIE_REG};

    always_comb begin
        w_trap  = 1'b1;
        w_mem   = 1'b0;
        w_cause = '0;
        w_tval  = '0;
        if (MEM_LAF)       begin w_mem = 1'b1; w_cause = XLEN'(5); w_tval = MEM_ADDR; end
        else if (MEM_LAM)  begin w_mem = 1'b1; w_cause = XLEN'(4); w_tval = MEM_ADDR; end
        else if (MEM_SAF)  begin w_mem = 1'b1; w_cause = XLEN'(7); w_tval = MEM_ADDR; end
        else if (MEM_SAM)  begin w_mem = 1'b1; w_cause = XLEN'(6); w_tval = MEM_ADDR; end
        else if (F_IAF)    begin w_cause = XLEN'(1); w_tval = F_PC; end
        else if (F_IAM)    begin w_cause = XLEN'(0); w_tval = F_PC; end
        else if (F_II)     begin w_cause = XLEN'(2); w_tval = XLEN'(F_INSTR); end
        else if (ECALL)    w_cause = XLEN'({2'b10, PRIVILEGE});
        else if (w_int_ext) w_cause = {1'b1, (XLEN-1)'(11)};
        else if (w_int_tmr) w_cause = {1'b1, (XLEN-1)'(7)};
        else               w_trap = 1'b0;
    end

    assign w_epc = w_mem ? MEM_PC : F_PC;

    // Trap entry stacks MIE into MPIE and records the old privilege in MPP; MRET unwinds it.
    assign w_mst_trap = {MSTATUS[XLEN-1:13], PRIVILEGE, MSTATUS[10:8], MSTATUS[3],
                         MSTATUS[6:4], 1'b0, MSTATUS[2:0]};
    assign w_mst_mret = {MSTATUS[XLEN-1:13], 2'b00, MSTATUS[10:8], 1'b1,
                         MSTATUS[6:4], MSTATUS[7], MSTATUS[2:0]};
    assign w_base     = MTVEC & ALIGN_MASK;

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only; reset also clears the latched context.
        if (RESET) begin
            r_state   <= IDLE;
            PRIVILEGE <= 2'b11;
            r_cause   <= '0;
            r_epc     <= '0;
            r_tval    <= '0;
            r_mpp     <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_trap) begin
                r_cause <= w_cause;
                r_epc   <= w_epc;
                r_tval  <= w_tval;
            end
            if (r_state == R_STATUS) r_mpp <= MSTATUS[12:11];
            if (r_state == S_REDIR)  PRIVILEGE <= 2'b11;
            if (r_state == R_REDIR)  PRIVILEGE <= r_mpp;
        end
    end

    always_comb begin
        // NOTE: every output and the next state get a default first so no latch is inferred.
        w_next      = r_state;
        CSR_WE      = 1'b0;
        CSR_WADDR   = 12'h000;
        CSR_WDATA   = '0;
        FLUSH       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;
        case (r_state)
            IDLE: begin
                if (w_trap)    w_next = S_EPC;
                else if (MRET) w_next = R_STATUS;
            end
            S_EPC: begin
                FLUSH     = 1'b1;
                CSR_WE    = 1'b1;
                CSR_WADDR = 12'h341;
                CSR_WDATA = {r_epc[XLEN-1:1], 1'b0};
                w_next    = S_CAUSE;
            end
            S_CAUSE: begin
                CSR_WE    = 1'b1;
                CSR_WADDR = 12'h342;
                CSR_WDATA = r_cause;
                w_next    = S_TVAL;
            end
            S_TVAL: begin
                CSR_WE    = 1'b1;
                CSR_WADDR = 12'h343;
                CSR_WDATA = r_tval;
                w_next    = S_STATUS;
            end
            S_STATUS: begin
                CSR_WE    = 1'b1;
                CSR_WADDR = 12'h300;
                CSR_WDATA = w_mst_trap;
                w_next    = S_REDIR;
            end
            S_REDIR: begin
                REDIRECT    = 1'b1;
                REDIRECT_PC = w_base;
`ifdef VECTORED_MTVEC_EN
                if (MTVEC[1:0] == 2'b01 && r_cause[XLEN-1])
                    REDIRECT_PC = w_base + {r_cause[XLEN-3:0], 2'b00};
`endif
                w_next      = IDLE;
            end
            R_STATUS: begin
                FLUSH     = 1'b1;
                CSR_WE    = 1'b1;
                CSR_WADDR = 12'h300;
                CSR_WDATA = w_mst_mret;
                w_next    = R_REDIR;
            end
            R_REDIR: begin
                REDIRECT    = 1'b1;
                REDIRECT_PC = MEPC;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign BUSY  = (r_state != IDLE);
    assign STALL = BUSY;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected CSR writes and redirects are queued at stimulus time
// and compared as the DUT emits them.
module tb_trap_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
    logic        ECALL, MRET, TIMER, EXTERNAL;
    logic [63:0] F_PC, MEM_PC, MEM_ADDR, MSTATUS, MIE_REG, MTVEC, MEPC;
    logic [31:0] F_INSTR;
    logic        CSR_WE, STALL, FLUSH, REDIRECT, BUSY;
    logic [11:0] CSR_WADDR;
    logic [63:0] CSR_WDATA, REDIRECT_PC;
    logic [1:0]  PRIVILEGE;

    trap_sequencer #(.XLEN(64), .MTVEC_ALIGN(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .F_IAM(F_IAM), .F_IAF(F_IAF), .F_II(F_II),
        .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF),
        .ECALL(ECALL), .MRET(MRET), .TIMER(TIMER), .EXTERNAL(EXTERNAL),
        .F_PC(F_PC), .MEM_PC(MEM_PC), .MEM_ADDR(MEM_ADDR), .F_INSTR(F_INSTR),
        .MSTATUS(MSTATUS), .MIE_REG(MIE_REG), .MTVEC(MTVEC), .MEPC(MEPC),
        .CSR_WE(CSR_WE), .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA),
        .STALL(STALL), .FLUSH(FLUSH), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .PRIVILEGE(PRIVILEGE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [63:0] exp_rd[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  m_priv;

    localparam logic [63:0] INT_EXT = 64'h8000_0000_0000_000B;
    localparam logic [63:0] INT_TMR = 64'h8000_0000_0000_0007;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_tvec(input logic [63:0] cause);
        logic [63:0] pc;
        pc = MTVEC & ~64'h3;
`ifdef VECTORED_MTVEC_EN
        if (MTVEC[1:0] == 2'b01 && cause[63]) pc = pc + {cause[61:0], 2'b00};
`endif
        return pc;
    endfunction

    // Reference model of one trap entry, evaluated with the CSR inputs present at detection.
    task automatic exp_trap(input logic [63:0] cause, input logic [63:0] epc, input logic [63:0] tval);
        logic [63:0] mst;
        mst        = MSTATUS;
        mst[7]     = MSTATUS[3];
        mst[3]     = 1'b0;
        mst[12:11] = m_priv;
        exp_wr.push_back('{12'h341, epc & ~64'h1});
        exp_wr.push_back('{12'h342, cause});
        exp_wr.push_back('{12'h343, tval});
        exp_wr.push_back('{12'h300, mst});
        exp_rd.push_back(exp_tvec(cause));
        m_priv = 2'b11;
    endtask

    task automatic exp_mret();
        logic [63:0] mst;
        mst        = MSTATUS;
        mst[3]     = MSTATUS[7];
        mst[7]     = 1'b1;
        mst[12:11] = 2'b00;
        exp_wr.push_back('{12'h300, mst});
        exp_rd.push_back(MEPC);
        m_priv = MSTATUS[12:11];
    endtask

    task automatic clear_events();
        {F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF} = '0;
        {ECALL, MRET, TIMER, EXTERNAL} = '0;
    endtask

    // Events are already driven; this fixes their detection edge and checks the 5-cycle timing.
    task automatic fire_trap(input string tag);
        @(posedge CLK); #1;
        clear_events();
        check({tag, "_flush"}, FLUSH, 1'b1);
        repeat (3) @(posedge CLK);
        #1 check({tag, "_no_early_redirect"}, REDIRECT, 1'b0);
        @(posedge CLK);
        #1 check({tag, "_redirect_cycle5"}, REDIRECT, 1'b1);
        @(posedge CLK);
        #1 check({tag, "_idle"}, BUSY, 1'b0);
        check({tag, "_priv"}, PRIVILEGE, m_priv);
    endtask

    task automatic fire_mret(input string tag);
        @(posedge CLK); #1;
        clear_events();
        check({tag, "_flush"}, FLUSH, 1'b1);
        @(posedge CLK);
        #1 check({tag, "_redirect"}, REDIRECT, 1'b1);
        @(posedge CLK);
        #1 check({tag, "_idle"}, BUSY, 1'b0);
        check({tag, "_priv"}, PRIVILEGE, m_priv);
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            wr_t w;
            check("stall_eq_busy", STALL, BUSY);
            if (CSR_WE) begin
                if (exp_wr.size() == 0) check("unexpected_csr_write", CSR_WE, 1'b0);
                else begin
                    w = exp_wr.pop_front();
                    check("csr_waddr", CSR_WADDR, w.addr);
                    check("csr_wdata", CSR_WDATA, w.data);
                end
            end else begin
                check("idle_csr_bus_zero", CSR_WDATA | 64'(CSR_WADDR), 64'h0);
            end
            if (REDIRECT) begin
                if (exp_rd.size() == 0) check("unexpected_redirect", REDIRECT, 1'b0);
                else check("redirect_pc", REDIRECT_PC, exp_rd.pop_front());
            end
        end
    end

    initial begin
        RESET = 1'b1;
        clear_events();
        F_PC = '0; MEM_PC = '0; MEM_ADDR = '0; F_INSTR = '0;
        MSTATUS = '0; MIE_REG = '0; MTVEC = 64'h8000; MEPC = '0;
        m_priv = 2'b11;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_csr_we", CSR_WE, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_stall", STALL, 1'b0);
        check("rst_flush", FLUSH, 1'b0);
        check("rst_redirect_pc", REDIRECT_PC, 64'h0);
        check("rst_priv", PRIVILEGE, 2'b11);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Load address misaligned from the memory stage.
        MEM_LAM = 1'b1; MEM_PC = 64'h1000; MEM_ADDR = 64'h2003;
        exp_trap(64'd4, 64'h1000, 64'h2003);
        fire_trap("lam");

        // Store fault beats illegal instruction; odd MEM_PC gets bit 0 cleared.
        MSTATUS = 64'h8;
        F_II = 1'b1; F_INSTR = 32'hdead_beef; F_PC = 64'h400;
        MEM_SAF = 1'b1; MEM_PC = 64'h2005; MEM_ADDR = 64'h3000;
        exp_trap(64'd7, 64'h2005, 64'h3000);
        fire_trap("saf_over_ii");

        F_II = 1'b1;
        exp_trap(64'd2, 64'h400, 64'hdead_beef);
        fire_trap("ii");

        F_IAM = 1'b1; F_IAF = 1'b1; F_PC = 64'h402;
        exp_trap(64'd1, 64'h402, 64'h402);
        fire_trap("iaf_over_iam");

        // Timer pending but globally disabled: nothing happens.
        MSTATUS = 64'h0; MIE_REG = 64'h80; TIMER = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1 check("tmr_masked_idle", BUSY, 1'b0);
        end
        MSTATUS = 64'h8;
        exp_trap(INT_TMR, 64'h402, 64'h0);
        fire_trap("tmr");

        // Exception wins over an enabled interrupt, which is then taken after one IDLE cycle.
        MIE_REG = 64'h880;
        MEM_LAF = 1'b1; MEM_PC = 64'h3000; MEM_ADDR = 64'h3100; EXTERNAL = 1'b1;
        exp_trap(64'd5, 64'h3000, 64'h3100);
        exp_trap(INT_EXT, 64'h402, 64'h0);
        @(posedge CLK); #1;
        MEM_LAF = 1'b0;
        repeat (4) @(posedge CLK);
        #1 check("laf_redirect", REDIRECT, 1'b1);
        @(posedge CLK);
        #1 check("pending_gap_idle", BUSY, 1'b0);
        @(posedge CLK);
        #1 check("pending_irq_taken", BUSY, 1'b1);
        EXTERNAL = 1'b0;
        repeat (4) @(posedge CLK);
        #1 check("ext_redirect", REDIRECT, 1'b1);
        @(posedge CLK);
        #1 check("ext_idle", BUSY, 1'b0);

        // MRET to U mode, ECALL from U, MRET back again.
        MIE_REG = 64'h0; MSTATUS = 64'h80; MEPC = 64'h5000;
        exp_mret();
        MRET = 1'b1;
        fire_mret("mret_to_u");

        F_PC = 64'h5004; ECALL = 1'b1;
        exp_trap(64'd8, 64'h5004, 64'h0);
        fire_trap("ecall_u");

        MEPC = 64'h5008;
        exp_mret();
        MRET = 1'b1;
        fire_mret("mret_again");

        // Reset in S_CAUSE: only mepc was written, privilege back to M.
        MEM_LAM = 1'b1; MEM_PC = 64'h6000;
        exp_wr.push_back('{12'h341, 64'h6000});
        @(posedge CLK); #1;
        clear_events();
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid_csr_we", CSR_WE, 1'b0);
        check("rst_mid_busy", BUSY, 1'b0);
        check("rst_mid_priv", PRIVILEGE, 2'b11);
        RESET = 1'b0;
        m_priv = 2'b11;
        repeat (6) @(posedge CLK);
        #1 check("rst_mid_no_restart", BUSY, 1'b0);

        // ECALL in M mode with a simultaneous MRET: trap taken, MRET dropped.
        MSTATUS = 64'h8; F_PC = 64'h7000; ECALL = 1'b1; MRET = 1'b1;
        exp_trap(64'd11, 64'h7000, 64'h0);
        fire_trap("ecall_m_over_mret");
        repeat (3) @(posedge CLK);
        #1 check("mret_dropped", BUSY, 1'b0);

        // Vectored MTVEC: interrupt vs exception, and non-vectored mode bits.
        MTVEC = 64'h8001; MIE_REG = 64'h800; EXTERNAL = 1'b1;
        exp_trap(INT_EXT, 64'h7000, 64'h0);
`ifdef VECTORED_MTVEC_EN
        check("vec_model_sanity", exp_rd[exp_rd.size()-1], 64'h802C);
`else
        check("vec_model_sanity", exp_rd[exp_rd.size()-1], 64'h8000);
`endif
        fire_trap("ext_vectored");

        MEM_SAM = 1'b1; MEM_PC = 64'h9000; MEM_ADDR = 64'h9001;
        exp_trap(64'd6, 64'h9000, 64'h9001);
        fire_trap("sam_vectored_base");

        MTVEC = 64'h8003; EXTERNAL = 1'b1;
        exp_trap(INT_EXT, 64'h7000, 64'h0);
        fire_trap("ext_mode3");

        repeat (2) @(posedge CLK);
        #1;
        check("wr_queue_empty", 64'(exp_wr.size()), 64'h0);
        check("rd_queue_empty", 64'(exp_rd.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
